// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract built from one shared 4-bit add/sub slice, one nibble per cycle, LSB first.
// Define OVF_EN to add the signed-overflow flag; otherwise ovf is tied low.
module addsub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 busy,
  output logic                 ovf
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_mode;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_carry_out;
  logic [W-1:0]     r_result;
  logic [IDX_W+1:0] w_base;
  logic [4:0]       w_sum;
  logic             w_last;

  // Shared slice: a + (b ^ {4{m}}) + cin, returning {cout, sum}.
  function automatic logic [4:0] slice_addsub(input logic [3:0] sa, input logic [3:0] sb,
                                              input logic m, input logic cin);
    return {1'b0, sa} + {1'b0, sb ^ {4{m}}} + {4'b0000, cin};
  endfunction

  assign w_base = {r_idx, 2'b00};
  assign w_sum  = slice_addsub(r_a[w_base +: 4], r_b[w_base +: 4], r_mode, r_carry);
  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef OVF_EN
  logic r_ovf;
`endif

  // Operand capture and nibble-serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= 1'b0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_result    <= '0;
`ifdef OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a         <= a;
            r_b         <= b;
            r_mode      <= mode;
            r_idx       <= '0;
            r_carry     <= mode;
            r_carry_out <= 1'b0;
            r_result    <= '0;
`ifdef OVF_EN
            r_ovf       <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          r_result[w_base +: 4] <= w_sum[3:0];
          r_carry               <= w_sum[4];
          if (w_last) begin
            r_carry_out <= w_sum[4];
`ifdef OVF_EN
            // The top slice's sum bit is the result MSB, so overflow is ready with out_valid.
            r_ovf <= (r_a[W-1] == (r_b[W-1] ^ r_mode)) & (w_sum[3] != r_a[W-1]);
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign carry_out = r_carry_out;
`ifdef OVF_EN
  assign ovf       = r_ovf;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed self-checking bench for addsub_seq_ctrl (default NIBBLES=4, W=16).
module tb_addsub_seq_ctrl;

  localparam int NIB = 4;
`ifdef OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        busy;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, check it, then complete the handshake.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tm, input logic [15:0] er, input logic ec, input logic eo);
    int cnt;
    in_valid = 1'b1; a = ta; b = tb; mode = tm;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check({tag, "_lat"}, 32'(cnt), 32'(NIB));
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(carry_out), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
    check({tag, "_ovld"}, 32'(out_valid), 32'd0);
  endtask

  logic [15:0] q_a   [3];
  logic [15:0] q_b   [3];
  logic        q_m   [3];
  logic [15:0] q_res [3];
  logic        q_c   [3];
  logic        q_o   [3];

  initial begin
    int issued;
    int done;
    int last_acc;
    int cyc;
    logic acc;
    logic hs;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_inrdy", 32'(in_ready), 32'd1);
    check("rst_ovld", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_cout", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    run_op("add",   16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("sub57", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub75", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("ripl",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON);

    // Backpressure in DONE with busy input side.
    in_valid = 1'b1; a = 16'h1234; b = 16'h0FFF; mode = 1'b0;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bp_lat", 32'(cyc), 32'(NIB));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'h1111 * 16'(i + 1); b = 16'h0F0F ^ 16'(i); mode = i[0];
      tick();
      check("bp_res", 32'(result), 32'h2233);
      check("bp_cout", 32'(carry_out), 32'd0);
      check("bp_inrdy", 32'(in_ready), 32'd0);
      check("bp_ovld", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle", 32'(in_ready), 32'd1);
    check("bp_keep", 32'(result), 32'h2233);

    // Reset at the second RUN edge abandons the operation.
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; mode = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_inrdy", 32'(in_ready), 32'd1);
    check("mr_ovld", 32'(out_valid), 32'd0);
    check("mr_res", 32'(result), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    run_op("post", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    q_a[0] = 16'h1111; q_b[0] = 16'h2222; q_m[0] = 1'b0; q_res[0] = 16'h3333; q_c[0] = 1'b0; q_o[0] = 1'b0;
    q_a[1] = 16'h8000; q_b[1] = 16'h0001; q_m[1] = 1'b1; q_res[1] = 16'h7FFF; q_c[1] = 1'b1; q_o[1] = OVF_ON;
    q_a[2] = 16'hABCD; q_b[2] = 16'h1234; q_m[2] = 1'b0; q_res[2] = 16'hBE01; q_c[2] = 1'b0; q_o[2] = 1'b0;
    issued = 0; done = 0; last_acc = -1;
    in_valid = 1'b1; out_ready = 1'b1;
    a = q_a[0]; b = q_b[0]; mode = q_m[0];
    for (int c = 0; c < 40 && done < 3; c++) begin
      acc = in_valid & in_ready;
      hs  = out_valid & out_ready;
      if (hs) begin
        check("b2b_res", 32'(result), 32'(q_res[done]));
        check("b2b_cout", 32'(carry_out), 32'(q_c[done]));
        check("b2b_ovf", 32'(ovf), 32'(q_o[done]));
        done++;
      end
      if (acc) begin
        if (last_acc >= 0) check("b2b_period", 32'(c - last_acc), 32'd6);
        last_acc = c;
        issued++;
      end
      tick();
      if (acc) begin
        if (issued < 3) begin
          a = q_a[issued]; b = q_b[issued]; mode = q_m[issued];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_issued", 32'(issued), 32'd3);
    check("b2b_done", 32'(done), 32'd3);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
